stage_melody_seq: RTL

- Parametrised melody sequencer that plays one song per game stage from an external note ROM.
- Replaces hard-coded per-stage music FSMs.
- Starts automatically when `cur_stage` changes to an enabled stage.
- Supports per-note durations, rests, an end marker, optional looping and abort-on-stage-change.
- Drives `sound_en`/`note_sel` into the existing tone generator.

---
 rtl/stage_melody_if.sv | 13 +
 rtl/stage_melody_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/stage_melody_if.sv
// Note-ROM read port: the sequencer (master) issues a one-cycle read strobe with {song, index};
// the ROM (slave) returns {end, rest, note, dur} on the following cycle.
interface stage_melody_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 9
);
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_rd, output rom_addr, input rom_data);
    modport slave  (input rom_rd, input rom_addr, output rom_data);
endinterface

// File: rtl/stage_melody_seq.sv
// Per-stage melody sequencer: fetches {end, rest, note, dur} entries from a note ROM and drives the tone generator.
// Optional MELODY_GAP_EN inserts a silent one-tick GAP after every note or rest; otherwise notes play legato.
module stage_melody_seq #(
    parameter int unsigned TICK_MAX  = 1_500_000,
    parameter int unsigned SONG_CNT  = 4,
    parameter int unsigned SONG_LEN  = 64,
    parameter int unsigned NOTE_W    = 4,
    parameter int unsigned DUR_W     = 3,
    parameter logic [7:0]  SONG_MASK = 8'b0000_1110
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        cur_stage,
    input  logic              loop_en,
    stage_melody_if.master    rom,
    output logic              sound_en,
    output logic [NOTE_W-1:0] note_sel,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W  = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int unsigned SONG_W = (SONG_CNT > 1) ? $clog2(SONG_CNT) : 1;
    localparam int unsigned ADDR_W = SONG_W + IDX_W;
    localparam int unsigned PRE_W  = $clog2(TICK_MAX);

    typedef struct packed {
        logic              eom;
        logic              rest;
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } entry_t;

`ifdef MELODY_GAP_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY} state_t;
`endif

    state_t              state_q, state_d;
    logic [2:0]          prev_stage_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [DUR_W-1:0]    tcnt_q, tcnt_d;
    logic                sound_en_q, sound_en_d;
    logic [NOTE_W-1:0]   note_sel_q, note_sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rom_rd_q, rom_rd_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;

    entry_t              ent_c;
    logic                change_c;
    logic                tick_c;
    logic                end_hit_c;
    logic [SONG_W-1:0]   song_c;

    assign ent_c    = rom.rom_data;
    assign change_c = (cur_stage != prev_stage_q);
    assign tick_c   = (pre_q == PRE_W'(TICK_MAX - 1));
    assign song_c   = SONG_W'(32'(cur_stage) % SONG_CNT);

    // Next-state and registered-output logic; a stage change overrides everything else.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pre_d      = pre_q;
        tcnt_d     = tcnt_q;
        sound_en_d = sound_en_q;
        note_sel_d = note_sel_q;
        done_d     = 1'b0;
        end_hit_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                sound_en_d = 1'b0;
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ent_c.eom) begin
                    end_hit_c = 1'b1;
                end else begin
                    pre_d      = '0;
                    tcnt_d     = ent_c.dur;
                    sound_en_d = !ent_c.rest;
                    if (!ent_c.rest) note_sel_d = ent_c.note;
                    state_d    = S_PLAY;
                end
            end
            S_PLAY: begin
                pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
                if (tick_c) begin
                    if (tcnt_q == '0) begin
                        if (idx_q == IDX_W'(SONG_LEN - 1)) begin
                            end_hit_c = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
`ifdef MELODY_GAP_EN
                            sound_en_d = 1'b0;
                            state_d    = S_GAP;
`else
                            state_d    = S_FETCH;
`endif
                        end
                    end else begin
                        tcnt_d = tcnt_q - DUR_W'(1);
                    end
                end
            end
`ifdef MELODY_GAP_EN
            S_GAP: begin
                sound_en_d = 1'b0;
                pre_d      = tick_c ? '0 : pre_q + PRE_W'(1);
                if (tick_c) state_d = S_FETCH;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (end_hit_c) begin
            if (loop_en) begin
                idx_d   = '0;
                state_d = S_FETCH;
            end else begin
                done_d     = 1'b1;
                sound_en_d = 1'b0;
                state_d    = S_IDLE;
            end
        end

        if (change_c) begin
            sound_en_d = 1'b0;
            idx_d      = '0;
            done_d     = 1'b0;
            state_d    = SONG_MASK[cur_stage] ? S_FETCH : S_IDLE;
        end

        rom_rd_d   = (state_d == S_FETCH);
        rom_addr_d = rom_rd_d ? {song_c, idx_d} : rom_addr_q;
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            prev_stage_q <= 3'd0;
            idx_q        <= '0;
            pre_q        <= '0;
            tcnt_q       <= '0;
            sound_en_q   <= 1'b0;
            note_sel_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rom_rd_q     <= 1'b0;
            rom_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_stage_q <= cur_stage;
            idx_q        <= idx_d;
            pre_q        <= pre_d;
            tcnt_q       <= tcnt_d;
            sound_en_q   <= sound_en_d;
            note_sel_q   <= note_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rom_rd_q     <= rom_rd_d;
            rom_addr_q   <= rom_addr_d;
        end
    end

    assign rom.rom_rd   = rom_rd_q;
    assign rom.rom_addr = rom_addr_q;
    assign sound_en     = sound_en_q;
    assign note_sel     = note_sel_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
